// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: two writeback sources (ALU, load) each
// feed a small FIFO; a round-robin arbiter drains one entry per cycle into a
// registered write port. Also flags read operands that still have a write
// queued or in flight, for read-after-write hazard stalls.
module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_address,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] src1_address,
  input  logic [ADDR_W-1:0] src2_address,
  output logic              src1_pending,
  output logic              src2_pending,
  output logic              idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Source index 0 is the ALU path, index 1 is the load path.
  logic [ADDR_W-1:0] fifo_addr_q [2][DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [2][DEPTH];
  logic [DATA_W-1:0] fifo_data_q [2][DEPTH];
  logic [DATA_W-1:0] fifo_data_d [2][DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];
  logic              alu_prio_q, alu_prio_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        has_entry;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] head_addr [2];
  logic [DATA_W-1:0] head_data [2];
  logic [PTR_W-1:0]  offs;
  logic              occupied;
  logic              src1_hit, src2_hit;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_addr[0] = alu_address;
  assign in_addr[1] = mem_address;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // even when it is being drained in the same cycle.
  always_comb begin
    ready = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s]     = rst && (cnt_q[s] < CNT_W'(DEPTH));
      has_entry[s] = (cnt_q[s] != '0);
      push[s]      = in_valid[s] && ready[s];
      head_addr[s] = fifo_addr_q[s][rd_ptr_q[s]];
      head_data[s] = fifo_data_q[s][rd_ptr_q[s]];
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  // Round-robin grant; the priority pointer only moves when both sources compete.
  always_comb begin
    grant      = '0;
    alu_prio_d = alu_prio_q;
    grant[0]   = has_entry[0] && (!has_entry[1] || alu_prio_q);
    grant[1]   = has_entry[1] && (!has_entry[0] || !alu_prio_q);
    if (has_entry[0] && has_entry[1]) begin
      alu_prio_d = !alu_prio_q;
    end
  end

  // FIFO next state: write at the tail on push, advance the head on grant.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(grant[s]);
      cnt_d[s]    = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
      for (int i = 0; i < DEPTH; i++) begin
        if (push[s] && (wr_ptr_q[s] == PTR_W'(i))) begin
          fifo_addr_d[s][i] = in_addr[s];
          fifo_data_d[s][i] = in_data[s];
        end else begin
          fifo_addr_d[s][i] = fifo_addr_q[s][i];
          fifo_data_d[s][i] = fifo_data_q[s][i];
        end
      end
    end
  end

  // Output stage: load the granted head; register 0 writes are swallowed.
  always_comb begin
    write_enable_d = 1'b0;
    address_d      = address_q;
    data_d         = data_q;
    if (grant[0]) begin
      address_d      = head_addr[0];
      data_d         = head_data[0];
      write_enable_d = (head_addr[0] != '0);
    end else if (grant[1]) begin
      address_d      = head_addr[1];
      data_d         = head_data[1];
      write_enable_d = (head_addr[1] != '0);
    end
  end

  // Hazard lookup across every occupied FIFO slot plus the in-flight write.
  always_comb begin
    src1_hit  = write_enable_q && (address_q == src1_address);
    src2_hit  = write_enable_q && (address_q == src2_address);
    offs      = '0;
    occupied  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs     = PTR_W'(i) - rd_ptr_q[s];
        occupied = ({1'b0, offs} < cnt_q[s]);
        if (occupied && (fifo_addr_q[s][i] == src1_address)) src1_hit = 1'b1;
        if (occupied && (fifo_addr_q[s][i] == src2_address)) src2_hit = 1'b1;
      end
    end
  end

  assign src1_pending = (src1_address != '0) && src1_hit;
  assign src2_pending = (src2_address != '0) && src2_hit;
  assign idle         = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !write_enable_q;
  assign write_enable = write_enable_q;
  assign address      = address_q;
  assign data         = data_q;

  // Control state and the write port; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q[0]    <= '0;
      rd_ptr_q[1]    <= '0;
      wr_ptr_q[0]    <= '0;
      wr_ptr_q[1]    <= '0;
      cnt_q[0]       <= '0;
      cnt_q[1]       <= '0;
      alu_prio_q     <= 1'b1;
      write_enable_q <= 1'b0;
      address_q      <= '0;
      data_q         <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      alu_prio_q     <= alu_prio_d;
      write_enable_q <= write_enable_d;
      address_q      <= address_d;
      data_q         <= data_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: per-source scoreboard queues filled on
// accepted handshakes, drained by a write-port monitor on the falling edge.
module tb_regfile_write_arbiter;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic              alu_ready, mem_ready;
  logic [ADDR_W-1:0] alu_address = '0, mem_address = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] src1_address = '0, src2_address = '0;
  logic              src1_pending, src2_pending, idle;

  regfile_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_address(alu_address), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address), .mem_data(mem_data),
    .write_enable(write_enable), .address(address), .data(data),
    .src1_address(src1_address), .src2_address(src2_address),
    .src1_pending(src1_pending), .src2_pending(src2_pending), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  exp_alu[$];
  wr_t  exp_mem[$];
  logic [ADDR_W-1:0] obs_addr[$];
  int   obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every register-file write must be the head of one source queue.
  always @(negedge clk) begin
    wr_t ha, hm;
    if (rst && write_enable) begin
      checks++;
      obs_addr.push_back(address);
      obs_cyc.push_back(cyc);
      ha = (exp_alu.size() > 0) ? exp_alu[0] : '0;
      hm = (exp_mem.size() > 0) ? exp_mem[0] : '0;
      if (exp_alu.size() > 0 && ha.a === address && ha.d === data) begin
        void'(exp_alu.pop_front());
      end else if (exp_mem.size() > 0 && hm.a === address && hm.d === data) begin
        void'(exp_mem.pop_front());
      end else begin
        errors++;
        $display("FAIL scoreboard_write: got addr=%0d data=0x%h, required alu head addr=%0d data=0x%h (%0d queued) or mem head addr=%0d data=0x%h (%0d queued)",
                 address, data, ha.a, ha.d, exp_alu.size(), hm.a, hm.d, exp_mem.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One stimulus cycle starting just after a rising edge; records accepted
  // entries (register 0 never produces a write, so it is not expected).
  task automatic drive_cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                             input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                             output logic a_rdy, output logic m_rdy);
    alu_valid = av; alu_address = aa; alu_data = ad;
    mem_valid = mv; mem_address = ma; mem_data = md;
    @(negedge clk);
    a_rdy = alu_ready;
    m_rdy = mem_ready;
    if (av && alu_ready && aa != '0) exp_alu.push_back({aa, ad});
    if (mv && mem_ready && ma != '0) exp_mem.push_back({ma, md});
    @(posedge clk); #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(idle && exp_alu.size() == 0 && exp_mem.size() == 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(idle === 1'b1 && exp_alu.size() == 0 && exp_mem.size() == 0)) begin
      errors++;
      $display("FAIL %s_drain: idle=%b alu_left=%0d mem_left=%0d, required idle=1 with no writes outstanding",
               name, idle, exp_alu.size(), exp_mem.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    exp_alu.delete();
    exp_mem.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    alu_valid = 1'b1; alu_address = 5'd7; alu_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", write_enable); end
      checks++; if (address !== '0) begin errors++; $display("FAIL reset_address: got %0d, required 0", address); end
      checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got 0x%h, required 0", data); end
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got alu=%b mem=%b, required 0/0", alu_ready, mem_ready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", idle); end
    end
    alu_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got alu=%b mem=%b, required 1/1", alu_ready, mem_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL release_idle: got %b, required 1", idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    src1_address = 5'd5;
    src2_address = 5'd6;
    alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (src1_pending !== 1'b0) begin errors++; $display("FAIL single_pending_before_push: got %b, required 0", src1_pending); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, required 1", alu_ready); end
    exp_alu.push_back({5'd5, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b, required 0", write_enable); end
    checks++; if (src1_pending !== 1'b1) begin errors++; $display("FAIL single_pending_queued: got %b, required 1", src1_pending); end
    checks++; if (src2_pending !== 1'b0) begin errors++; $display("FAIL single_src2_pending: got %b, required 0", src2_pending); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b, required 0", idle); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_enable !== 1'b1 || address !== 5'd5 || data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write: got we=%b addr=%0d data=0x%h, required we=1 addr=5 data=0xdeadbeef", write_enable, address, data); end
    checks++; if (src1_pending !== 1'b1) begin errors++; $display("FAIL single_pending_inflight: got %b, required 1", src1_pending); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_we_one_cycle: got %b, required 0", write_enable); end
    checks++; if (src1_pending !== 1'b0) begin errors++; $display("FAIL single_pending_cleared: got %b, required 0", src1_pending); end
    checks++; if (address !== 5'd5 || data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold: got addr=%0d data=0x%h, required 5/0xdeadbeef", address, data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b, required 1", idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_full();
    logic       ar, mr;
    logic [7:0] mr_log;
    src2_address = 5'd16;
    mr_log = '0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, ADDR_W'(8 + i), 32'hA000_0000 + i, 1'b1, ADDR_W'(16 + i), 32'hB000_0000 + i, ar, mr);
      mr_log[i] = mr;
      if (i == 0) begin
        checks++; if (src2_pending !== 1'b1) begin errors++; $display("FAIL full_src2_pending: got %b, required 1", src2_pending); end
      end
    end
    checks++; if (mr_log !== 8'b1010_1011) begin
      errors++; $display("FAIL full_mem_ready_pattern: got %b, required 10101011", mr_log); end
    drain("fifo_full");
  endtask

  task automatic test_contention();
    logic ar, mr;
    logic [ADDR_W-1:0] order [4];
    order[0] = 5'd1; order[1] = 5'd3; order[2] = 5'd2; order[3] = 5'd4;
    pulse_reset();
    obs_addr.delete();
    obs_cyc.delete();
    drive_cycle(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd3, 32'h0000_00B3, ar, mr);
    drive_cycle(1'b1, 5'd2, 32'h0000_00A2, 1'b1, 5'd4, 32'h0000_00B4, ar, mr);
    drain("contention");
    checks++;
    if (obs_addr.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d writes, required 4", obs_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (obs_addr[k] !== order[k]) begin errors++; $display("FAIL contention_order[%0d]: got addr=%0d, required %0d", k, obs_addr[k], order[k]); end
        checks++; if (obs_cyc[k] != obs_cyc[0] + k) begin errors++; $display("FAIL contention_gap[%0d]: got cycle %0d, required %0d", k, obs_cyc[k], obs_cyc[0] + k); end
      end
    end
  endtask

  task automatic test_addr_zero();
    logic ar, mr;
    src1_address = 5'd0;
    drive_cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0, ar, mr);
    checks++; if (src1_pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b, required 0", src1_pending); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL zero_queued_idle: got %b, required 0", idle); end
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_enable !== 1'b0 || address !== 5'd0 || data !== 32'h0000_1234) begin
      errors++; $display("FAIL zero_slot: got we=%b addr=%0d data=0x%h, required we=0 addr=0 data=0x1234", write_enable, address, data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL zero_idle_after: got %b, required 1", idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic ar, mr;
    src1_address = 5'd10;
    drive_cycle(1'b1, 5'd9,  32'h0000_00C9, 1'b1, 5'd17, 32'h0000_00D1, ar, mr);
    drive_cycle(1'b1, 5'd10, 32'h0000_00CA, 1'b0, 5'd0,  32'h0, ar, mr);
    rst = 1'b0;
    exp_alu.delete();
    exp_mem.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (write_enable !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL midrst_state: got we=%b idle=%b, required 0/1", write_enable, idle); end
      checks++; if (address !== '0 || data !== '0) begin errors++; $display("FAIL midrst_port: got addr=%0d data=0x%h, required 0/0", address, data); end
      checks++; if (src1_pending !== 1'b0) begin errors++; $display("FAIL midrst_pending: got %b, required 0", src1_pending); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (write_enable !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL midrst_no_write[%0d]: got we=%b idle=%b, required 0/1", i, write_enable, idle); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_contention();
    test_addr_zero();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
